// File: rtl/sisc_pkg.sv
// Shared constants for the SISC memory arbiter: bus widths, the arbiter
// state encoding, the fetch-starvation limit and the grant-select type.
package sisc_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 3;

   // Arbiter state encoding, kept as plain constants for older tools
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Which port owns the transaction currently in flight
   typedef enum logic {
      GNT_DM = 1'b0,
      GNT_IF = 1'b1
   } gnt_e;

   // Next starvation count after an arbitration in IDLE.
   // Fetch winning clears it; data winning over a waiting fetch bumps it,
   // saturating at STARVE_MAX; data winning alone leaves it alone.
   function automatic logic [1:0] starve_next(input logic [1:0] cur,
                                              input logic       fetch_won,
                                              input logic       fetch_waiting);
      logic [1:0] nxt;
      nxt = cur;
      if (fetch_won) begin
         nxt = 2'd0;
      end else if (fetch_waiting && (cur != 2'(STARVE_MAX))) begin
         nxt = cur + 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data (load/store) share one
// synchronous single-port memory. Each access is IDLE -> ACCESS -> RESP.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; arbitrate when if_req or dm_req is high
//   ACCESS | mem_en strobe for the granted port (mem_we for a store)
//   RESP   | ack the granted port; memory read data is valid this cycle
//
// Data normally wins; after three data wins in a row over a waiting fetch,
// the fetch is forced through once so instruction fetch cannot starve.
//
// The memory returns read data during RESP, and the ack is in the same
// cycle, so the rdata outputs bypass mem_rdata during the ack cycle and
// then hold the registered copy until the next ack of that port.
module mem_arb
   import sisc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_f,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [1:0]        starve_q;
   gnt_e              gnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;

   logic in_idle;
   logic in_access;
   logic in_resp;
   logic arb_go;
   logic fetch_wins;

   assign in_idle   = (state_q == ST_IDLE);
   assign in_access = (state_q == ST_ACCESS);
   assign in_resp   = (state_q == ST_RESP);

   assign arb_go     = in_idle && (if_req || dm_req);
   assign fetch_wins = if_req && (!dm_req || (starve_q == 2'(STARVE_MAX)));

   // Next-state: one cycle each in ACCESS and RESP, always back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (arb_go) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and starvation counter; the counter only moves on an arbitration
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         state_q  <= ST_IDLE;
         starve_q <= 2'd0;
      end else begin
         state_q <= state_d;
         if (arb_go) begin
            starve_q <= starve_next(starve_q, fetch_wins, if_req);
         end
      end
   end

   // Latch the winner's access fields on the IDLE->ACCESS edge
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         gnt_q   <= GNT_DM;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (arb_go) begin
         if (fetch_wins) begin
            gnt_q   <= GNT_IF;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
         end else begin
            gnt_q   <= GNT_DM;
            we_q    <= dm_we;
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
         end
      end
   end

   // Keep the read word of the last completed read for each port
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (in_resp) begin
         if (gnt_q == GNT_IF) begin
            if_rdata_q <= mem_rdata;
         end else if (!we_q) begin
            dm_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_en    = in_access;
   assign mem_we    = in_access && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = !in_idle;

   // Only one grant is ever in flight, so the two acks are exclusive
   assign if_ack = in_resp && (gnt_q == GNT_IF);
   assign dm_ack = in_resp && (gnt_q == GNT_DM);

   assign if_rdata = if_ack ? mem_rdata : if_rdata_q;
   assign dm_rdata = (dm_ack && !we_q) ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios with literal
// expectations plus a transaction-level model checked every cycle.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        if_req;
   logic [15:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0BAD_0BAD;
   logic        busy;

   logic [31:0] next_rdata;
   int tests = 0;
   int fails = 0;

   mem_arb dut (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // synchronous memory: read data appears the cycle after a read strobe
   always @(posedge clk)
      mem_rdata <= (mem_en && !mem_we) ? next_rdata : 32'h0BAD_0BAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model ----------------
   // m_t: cycles elapsed since the grant (-1 = no transaction in flight)
   int          m_t = -1;
   int          m_starve = 0;
   bit          m_fetch;
   bit          m_we;
   logic [15:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_if_rd = 0;
   logic [31:0] m_dm_rd = 0;

   always @(negedge clk) begin
      if (rst_f) begin
         m_t = -1; m_starve = 0; m_if_rd = 0; m_dm_rd = 0;
      end else begin
         if (m_t == 1 && m_fetch) m_if_rd = mem_rdata;
         if (m_t == 1 && !m_fetch && !m_we) m_dm_rd = mem_rdata;
         check("m_busy",   32'(busy),   32'(m_t >= 0));
         check("m_mem_en", 32'(mem_en), 32'(m_t == 0));
         check("m_mem_we", 32'(mem_we), 32'(m_t == 0 && m_we));
         check("m_if_ack", 32'(if_ack), 32'(m_t == 1 && m_fetch));
         check("m_dm_ack", 32'(dm_ack), 32'(m_t == 1 && !m_fetch));
         check("m_ack_excl", 32'(if_ack && dm_ack), 32'd0);
         check("m_if_rdata", if_rdata, m_if_rd);
         check("m_dm_rdata", dm_rdata, m_dm_rd);
         if (m_t == 0) begin
            check("m_mem_addr",  32'(mem_addr), 32'(m_addr));
            check("m_mem_wdata", mem_wdata, m_wdata);
         end
         if (m_t == 1) m_t = -1;
         else if (m_t == 0) m_t = 1;
         else if (if_req || dm_req) begin
            m_fetch = if_req && (!dm_req || m_starve == 3);
            if (m_fetch) m_starve = 0;
            else if (if_req && m_starve < 3) m_starve++;
            m_addr  = m_fetch ? if_addr : dm_addr;
            m_we    = m_fetch ? 1'b0 : dm_we;
            m_wdata = m_fetch ? 32'd0 : dm_wdata;
            m_t     = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int  n_dm;
      bit  got;
      bit  first_dm;
      rst_f = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
      dm_addr = 0; dm_wdata = 0; next_rdata = 0;
      repeat (3) step();
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_mem_en",   32'(mem_en), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      rst_f = 1'b0;
      step();

      // lone fetch
      if_req = 1; if_addr = 16'h0010; next_rdata = 32'hDEADBEEF;
      step();
      check("fetch_en",   32'(mem_en), 32'd1);
      check("fetch_addr", 32'(mem_addr), 32'h0010);
      check("fetch_we",   32'(mem_we), 32'd0);
      step();
      check("fetch_ack",   32'(if_ack), 32'd1);
      check("fetch_rdata", if_rdata, 32'hDEADBEEF);
      if_req = 0;
      step();
      check("fetch_idle", 32'(busy), 32'd0);
      check("fetch_hold", if_rdata, 32'hDEADBEEF);

      // load, then store must leave dm_rdata alone
      dm_req = 1; dm_we = 0; dm_addr = 16'h0300; next_rdata = 32'hCAFEF00D;
      step(); step();
      check("load_ack",   32'(dm_ack), 32'd1);
      check("load_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 0;
      step();
      dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 32'h12345678;
      step();
      check("store_en",    32'(mem_en), 32'd1);
      check("store_we",    32'(mem_we), 32'd1);
      check("store_addr",  32'(mem_addr), 32'h0200);
      check("store_wdata", mem_wdata, 32'h12345678);
      step();
      check("store_ack",   32'(dm_ack), 32'd1);
      check("store_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 0; dm_we = 0;
      step();
      check("store_hold", dm_rdata, 32'hCAFEF00D);

      // simultaneous requests: data first, fetch 3 cycles later
      if_req = 1; if_addr = 16'h0040;
      dm_req = 1; dm_addr = 16'h0080; next_rdata = 32'h11111111;
      step();
      check("sim_first_addr", 32'(mem_addr), 32'h0080);
      step();
      check("sim_dm_ack", 32'(dm_ack), 32'd1);
      check("sim_if_ack_c2", 32'(if_ack), 32'd0);
      check("sim_dm_rdata", dm_rdata, 32'h11111111);
      dm_req = 0; next_rdata = 32'h22222222;
      step();
      check("sim_c3_acks", 32'(if_ack || dm_ack), 32'd0);
      step();
      check("sim_second_addr", 32'(mem_addr), 32'h0040);
      check("sim_c4_acks", 32'(if_ack || dm_ack), 32'd0);
      step();
      check("sim_if_ack_c5", 32'(if_ack), 32'd1);
      check("sim_if_rdata",  if_rdata, 32'h22222222);
      if_req = 0;
      step();

      // starvation: three data wins, then the fetch is forced through
      if_req = 1; if_addr = 16'h0044;
      dm_req = 1; dm_we = 0; dm_addr = 16'h0090; next_rdata = 32'h77770000;
      n_dm = 0; got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         step();
         if (dm_ack) n_dm++;
         if (if_ack) got = 1;
      end
      check("starve_if_seen",   32'(got), 32'd1);
      check("starve_dm_before", 32'(n_dm), 32'd3);
      // counter cleared: with both still requesting, data wins next
      got = 0; first_dm = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         step();
         if (dm_ack || if_ack) begin
            got = 1; first_dm = dm_ack;
         end
      end
      check("starve_clr_seen", 32'(got), 32'd1);
      check("starve_clr_dm",   32'(first_dm), 32'd1);
      dm_req = 0; if_req = 0;
      step();

      // reset during ACCESS
      if_req = 1; if_addr = 16'h0066; next_rdata = 32'h66666666;
      step();
      check("rst_mid_en_pre", 32'(mem_en), 32'd1);
      rst_f = 1;
      #1;
      check("rst_mid_en",   32'(mem_en), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_ack",  32'(if_ack || dm_ack), 32'd0);
      step();
      check("rst_hold_ack", 32'(if_ack || dm_ack), 32'd0);
      rst_f = 0;
      step();
      check("rst_regrant_en",   32'(mem_en), 32'd1);
      check("rst_regrant_addr", 32'(mem_addr), 32'h0066);
      step();
      check("rst_regrant_ack", 32'(if_ack), 32'd1);
      if_req = 0;
      step();

      // withdrawal after grant
      dm_req = 1; dm_we = 0; dm_addr = 16'h0120; next_rdata = 32'h5A5A5A5A;
      step();
      check("wd_en", 32'(mem_en), 32'd1);
      dm_req = 0;
      step();
      check("wd_ack",   32'(dm_ack), 32'd1);
      check("wd_rdata", dm_rdata, 32'h5A5A5A5A);
      step();
      check("wd_idle", 32'(busy), 32'd0);
      step();
      check("wd_no_regrant", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL provide port clk  input  1  system clock; all state changes on the posedge.
REQ-002 SHALL provide port rst_f  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-003 SHALL provide port if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-004 SHALL provide port if_addr  input  16  fetch address, stable while if_req is high.
REQ-005 SHALL provide port if_rdata  output  32  fetched word, registered, held until the next fetch ack.
REQ-006 SHALL provide port if_ack  output  1  one-cycle pulse when the fetch completes.
REQ-007 SHALL provide port dm_req  input  1  data request from LOD/STR, level, held until dm_ack.
REQ-008 SHALL provide port dm_we  input  1  1 = store, 0 = load; stable while dm_req is high.
REQ-009 SHALL provide port dm_addr  input  16  data address, stable while dm_req is high.
REQ-010 SHALL provide port dm_wdata  input  32  store data, stable while dm_req is high.
REQ-011 SHALL provide port dm_rdata  output  32  loaded word, registered, held until the next load ack.
REQ-012 SHALL provide port dm_ack  output  1  one-cycle pulse when the data access completes.
REQ-013 SHALL provide port mem_en  output  1  memory access strobe.
REQ-014 SHALL provide port mem_we  output  1  memory write enable; only meaningful with mem_en.
REQ-015 SHALL provide port mem_addr  output  16  memory address, registered.
REQ-016 SHALL provide port mem_wdata  output  32  memory write data, registered.
REQ-017 SHALL provide port mem_rdata  input  32  synchronous memory read data, valid the cycle after a read strobe.
REQ-018 SHALL provide port busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement a three-state FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: leave only when if_req or dm_req is high.
- ACCESS and RESP: each lasts exactly one cycle.
REQ-020 SHALL resolve arbitration in IDLE:
- dm_req wins over if_req,
- unless starve_cnt equals 3 and if_req is high, in which case fetch wins.
REQ-021 SHALL manage starve_cnt (2-bit) as follows:
- increment, saturating at 3, when dm wins while if_req is high;
- clear when fetch wins;
- unchanged otherwise.
REQ-022 SHALL, on the IDLE->ACCESS edge, register the winner's fields:
- mem_addr;
- mem_wdata (dm_wdata for data, 0 for fetch);
- mem_we (dm_we for data, 0 for fetch);
- a 1-bit grant select.
REQ-023 SHALL drive mem_en high exclusively during ACCESS, with mem_we high in that cycle only for a granted store.
REQ-024 SHALL, in RESP, pulse the granted port's ack for one cycle and capture mem_rdata into that port's rdata register on reads; stores leave dm_rdata unchanged.
REQ-025 SHALL use this latency: request high in IDLE at cycle 0 -> mem_en in cycle 1 -> ack and valid rdata in cycle 2 -> IDLE in cycle 3; peak throughput is one access per 3 cycles.
REQ-026 SHALL always return to IDLE from RESP, so a request still high during its own ack cycle is not re-granted until cycle 3 or later.
REQ-027 SHALL complete and acknowledge a granted transaction even if its req drops after the grant.
REQ-028 SHALL keep the losing request pending, unaltered, for the next IDLE arbitration.
REQ-029 SHALL never assert if_ack and dm_ack in the same cycle.

Reset
REQ-030 SHALL, on rst_f high, asynchronously force:
- state IDLE, starve_cnt 0;
- mem_en, mem_we, if_ack, dm_ack, busy all 0;
- mem_addr, mem_wdata, if_rdata, dm_rdata all 0.
REQ-031 SHALL abandon any in-flight transaction on reset, with no ack issued, and arbitrate afresh on the first posedge after rst_f falls.

Structure
REQ-032 SHALL place the state encoding (IDLE=0, ACCESS=1, RESP=2), ADDR_W=16, DATA_W=32 and STARVE_MAX=3 in the shared package sisc_pkg.
REQ-033 SHALL be one flat module with no sub-module; the arbitration logic is too small to split.

Verification
REQ-034 SHALL cover a lone fetch: if_req=1, if_addr=0x0010, mem_rdata=0xDEADBEEF -> mem_en in cycle 1 with mem_addr=0x0010, if_ack and if_rdata=0xDEADBEEF in cycle 2.
REQ-035 SHALL cover a store: dm_req=1, dm_we=1, dm_addr=0x0200, dm_wdata=0x12345678 -> mem_en=mem_we=1 with those values in cycle 1, dm_ack in cycle 2, dm_rdata unchanged.
REQ-036 SHALL cover simultaneous requests: if_req=dm_req=1 in the same IDLE cycle -> data granted first, fetch granted at the next IDLE, acks exactly 3 cycles apart.
REQ-037 SHALL cover starvation: dm_req held high with four back-to-back loads while if_req is high -> the fourth grant goes to fetch (starve_cnt=3) and starve_cnt clears to 0.
REQ-038 SHALL cover mid-operation reset: rst_f pulsed high during ACCESS -> mem_en drops immediately, no ack, busy=0; after release, a pending if_req is granted in the first cycle.
REQ-039 SHALL cover request withdrawal: dm_req dropped in the ACCESS cycle -> dm_ack still pulses in cycle 2.
